dbus_sram_responder: RTL

//   Memory-side responder for the data bus (dbus_req_t in, dbus_resp_t out).
//   It serves the memory stage's load/store requests from an internal 64-bit-wide SRAM array.
//   Per-byte write strobes are applied; reads return the whole aligned doubleword.

---
 rtl/dbus_sram_responder_if.sv | 39 +++
 rtl/dbus_sram_responder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder_if.sv
// ============================================================================
// dbus_sram_responder_if : data-bus request/response types and bus interface
// Revision: 1.0
// ============================================================================
`default_nettype none

package dbus_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

interface dbus_sram_responder_if;
  import dbus_pkg::*;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

`default_nettype wire

// File: rtl/dbus_sram_responder.sv
// ============================================================================
// dbus_sram_responder : 64-bit SRAM behind the data bus, programmable latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  dbus_sram_responder_if.slave dbus,
  output logic               busy,
  output logic [31:0]        req_cnt
);

  localparam int IDX_W = $clog2(WORDS);
  // Zero latency skips WAIT and serves the live request straight from IDLE.
  localparam bit         c_direct  = (LATENCY == 0);
  localparam logic [3:0] c_cntLoad = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state, w_stateNext;
  logic [3:0]       r_cnt, w_cntNext;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_strobe;
  logic [63:0]      r_wdata;
  logic             r_addrOk, r_dataOk;
  logic [63:0]      r_rdata;
  logic [31:0]      r_reqCnt;
  logic [63:0]      r_mem [WORDS];

  logic             w_accept, w_access, w_addrOkNext, w_dataOkNext;
  logic [IDX_W-1:0] w_reqIdx, w_idx;
  logic [7:0]       w_strobe;
  logic [63:0]      w_wdata;
  logic             w_unused;

  assign w_reqIdx = dbus.dreq.addr[IDX_W+2:3];
  assign w_idx    = c_direct ? w_reqIdx         : r_idx;
  assign w_strobe = c_direct ? dbus.dreq.strobe : r_strobe;
  assign w_wdata  = c_direct ? dbus.dreq.data   : r_wdata;
  assign w_unused = ^{dbus.dreq.addr[63:IDX_W+3], dbus.dreq.addr[2:0], dbus.dreq.size};

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_addrOkNext = 1'b0;
    w_dataOkNext = 1'b0;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      IDLE: begin
        if (dbus.dreq.valid) begin
          w_accept     = 1'b1;
          w_addrOkNext = 1'b1;
          w_cntNext    = c_cntLoad;
          if (c_direct) begin
            w_access     = 1'b1;
            w_dataOkNext = 1'b1;
            w_stateNext  = RESP;
          end else begin
            w_stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (!dbus.dreq.valid) begin
          w_stateNext = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_access     = 1'b1;
          w_dataOkNext = 1'b1;
          w_stateNext  = RESP;
        end else begin
          w_cntNext = r_cnt - 4'd1;
        end
      end
      RESP:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addrOk <= 1'b0;
      r_dataOk <= 1'b0;
      r_rdata  <= 64'd0;
      r_reqCnt <= 32'd0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_addrOk <= w_addrOkNext;
      r_dataOk <= w_dataOkNext;
      if (w_access) r_rdata <= r_mem[w_idx];
      if (r_state == RESP) r_reqCnt <= r_reqCnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx    <= w_reqIdx;
      r_strobe <= dbus.dreq.strobe;
      r_wdata  <= dbus.dreq.data;
    end
  end

  // Writes commit only on the edge that enters RESP, so an abort or reset leaves memory intact.
  always_ff @(posedge clk) begin
    if (reset && w_access) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strobe[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign dbus.dresp.addr_ok = r_addrOk;
  assign dbus.dresp.data_ok = r_dataOk;
  assign dbus.dresp.data    = r_rdata;
  assign busy               = (r_state != IDLE);
  assign req_cnt            = r_reqCnt;

  a_strobeSize : assert property (@(posedge clk) disable iff (!reset)
    (w_accept && (|dbus.dreq.strobe)) |-> ($countones(dbus.dreq.strobe) == (32'd1 << dbus.dreq.size)));

endmodule

`default_nettype wire
